// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    // Loader FSM: IDLE -> LEN0 -> LEN1 -> DATA -> DONE (LEN1 may go straight to DONE when N == 0)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Stream header is a 16-bit little-endian word count
    localparam int unsigned HDR_BYTES      = 2;
    // Instruction words are packed from four little-endian bytes
    localparam int unsigned BYTES_PER_WORD = 4;

    // The loader is busy (CPU held in reset, stream accepted) in every state that consumes bytes
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses with the 4th byte.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;

    // Place the incoming byte in its lane; the completed word is presented combinationally
    // so the loader can register it on the same edge that accepts the last byte.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (byte_valid) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_data;
            cnt_d = cnt_q + 1'b1;
        end
        if (clear) begin
            cnt_d = '0;
        end
        word_valid = byte_valid && (cnt_q == LAST_LANE);
        word_data  = word_d;
    end

    // Lane counter is control state: cleared by reset or a new load so partial words are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Word assembly register: every lane is overwritten before use, so it carries no reset
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a length-prefixed byte stream and emits
// one write strobe per packed 32-bit instruction word, holding the CPU in reset meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic        in_ready_q, in_ready_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        hs;
    logic [15:0] len_full;
    logic        pk_clear;
    logic        pk_valid;
    logic        pk_word_valid;
    logic [31:0] pk_word;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_valid (pk_word_valid),
        .word_data  (pk_word)
    );

    // Next-state and next-output computation; every output is registered from these values
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        pk_clear   = 1'b0;
        pk_valid   = 1'b0;
        hs         = in_valid && in_ready_q;
        len_full   = {in_data, len_q[7:0]};

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LEN0;
                    len_d      = '0;
                    word_idx_d = '0;
                    err_d      = 1'b0;
                    pk_clear   = 1'b1;
                end
            end
            ST_LEN0: begin
                if (hs) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (hs) begin
                    len_d = len_full;
                    if (32'(len_full) > DEPTH_U) begin
                        err_d = 1'b1;
                    end
                    state_d = (len_full == 16'd0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                pk_valid = hs;
                if (pk_word_valid) begin
                    // Words past the memory depth are consumed but never written
                    if (32'(word_idx_q) < DEPTH_U) begin
                        we_d    = 1'b1;
                        waddr_d = {{(30-AW){1'b0}}, word_idx_q[AW-1:0], 2'b00};
                        wdata_d = pk_word;
                    end
                    word_idx_d = word_idx_q + 16'd1;
                    if ((word_idx_q + 16'd1) == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = state_is_busy(state_d);
        busy_d     = state_is_busy(state_d);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset to the idle, all-zero condition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
